// File: rtl/mem_stage_mc_pkg.sv
// Shared types and defaults for the multi-cycle memory stage.
// State encodings and default widths live here.
package mem_stage_mc_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

endpackage

// File: rtl/mem_stage_mc_if.sv
// Request/ack bus between the memory stage and data memory.
// master = controller side, slave = memory side.
interface mem_stage_mc_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              mem_req;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_dump;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_err;

   modport master (
      output mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
      input  mem_ack, mem_rdata, mem_err
   );

   modport slave (
      input  mem_req, mem_wr, mem_addr, mem_wdata, mem_dump,
      output mem_ack, mem_rdata, mem_err
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the BUSY state.
// expired_o flags the last permitted BUSY cycle.
module mem_wait_timer #(
   parameter int TIMEOUT = 15,
   localparam int W = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // clear wins over enable
   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (en_i)
         count_d = count_q + W'(1);
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // this BUSY cycle is the TIMEOUT-th one
   assign expired_o = (count_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle memory stage: issues a load/store, stalls
// until ack/timeout/reject, registers data, sticky err.
module mem_stage_mc
   import mem_stage_mc_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] XOut,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              createdump,
   output logic              Stall,
   output logic              Done,
   output logic [DATA_W-1:0] MemOut,
   output logic              err,
   mem_stage_mc_if.master    mem
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;
   logic              expired;
   logic              x_bad;
   logic              req;

   assign req = MemRead | MemWrite;

`ifndef SYNTHESIS
   assign x_bad = $isunknown({MemRead, MemWrite, createdump,
                              XOut, WriteData});
`else
   assign x_bad = 1'b0;
`endif

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_d != BUSY),
      .en_i      (state_q == BUSY),
      .expired_o (expired)
   );

   // next state, datapath capture and error accumulation
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wr_d    = wr_q;
      out_d   = out_q;
      err_d   = err_q | x_bad;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d  = XOut;
               wdata_d = WriteData;
               wr_d    = MemWrite;
               if (MemRead && MemWrite)
                  err_d = 1'b1;
               if (ALIGN_CHECK != 0 && XOut[0]) begin
                  err_d   = 1'b1;
                  out_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            if (mem.mem_ack) begin
               if (!wr_q)
                  out_d = mem.mem_rdata;
               if (mem.mem_err)
                  err_d = 1'b1;
               state_d = DONE;
            end else if (expired) begin
               err_d   = 1'b1;
               out_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign Stall = (state_q == BUSY) || (state_q == IDLE && req);
   assign Done  = (state_q == DONE);
   assign MemOut = out_q;
   assign err    = err_q;

   assign mem.mem_req   = (state_q == BUSY);
   assign mem.mem_wr    = wr_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_dump  = createdump;
endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc.
// Steps: drive after edge+1, settle 1, check.
module tb_mem_stage_mc;
   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite, createdump;
   logic [15:0] XOut, WriteData;
   logic        Stall, Done, err;
   logic [15:0] MemOut;
   int          n_cmp = 0;
   int          n_err = 0;

   mem_stage_mc_if #(.ADDR_W(16), .DATA_W(16)) mem ();

   mem_stage_mc #(
      .DATA_W(16), .ADDR_W(16), .TIMEOUT(15), .ALIGN_CHECK(1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .XOut       (XOut),
      .WriteData  (WriteData),
      .createdump (createdump),
      .Stall      (Stall),
      .Done       (Done),
      .MemOut     (MemOut),
      .err        (err),
      .mem        (mem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      MemRead = 0; MemWrite = 0;
      mem.mem_ack = 0; mem.mem_err = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle_in();
      tick(); tick();
      rst = 0;
   endtask

   // zero-wait load, ends one cycle into IDLE
   task automatic quick_load(input logic [15:0] a,
                             input logic [15:0] d, input logic e);
      MemRead = 1; XOut = a;
      tick();
      mem.mem_ack = 1; mem.mem_rdata = d; mem.mem_err = e;
      tick();
      idle_in();
      tick();
   endtask

   initial begin
      createdump = 0; XOut = '0; WriteData = '0;
      mem.mem_rdata = '0;
      do_reset();
      #1;
      chk("rst_stall", Stall, 0);
      chk("rst_done", Done, 0);
      chk("rst_memout", MemOut, 0);
      chk("rst_err", err, 0);
      chk("rst_req", mem.mem_req, 0);
      chk("rst_addr", mem.mem_addr, 0);
      chk("rst_wdata", mem.mem_wdata, 0);
      chk("rst_wr", mem.mem_wr, 0);
      createdump = 1; #1;
      chk("dump_1", mem.mem_dump, 1);
      createdump = 0; #1;
      chk("dump_0", mem.mem_dump, 0);

      // aligned load, ack in first BUSY cycle
      MemRead = 1; XOut = 16'h0010; #1;
      chk("ld_c0_stall", Stall, 1);
      chk("ld_c0_req", mem.mem_req, 0);
      tick();
      mem.mem_ack = 1; mem.mem_rdata = 16'hBEEF; #1;
      chk("ld_c1_stall", Stall, 1);
      chk("ld_c1_req", mem.mem_req, 1);
      chk("ld_c1_addr", mem.mem_addr, 16'h0010);
      chk("ld_c1_wr", mem.mem_wr, 0);
      chk("ld_c1_done", Done, 0);
      tick();
      mem.mem_ack = 0; #1;
      chk("ld_c2_done", Done, 1);
      chk("ld_c2_stall", Stall, 0);
      chk("ld_c2_req", mem.mem_req, 0);
      chk("ld_c2_out", MemOut, 16'hBEEF);
      chk("ld_c2_err", err, 0);
      idle_in();
      tick();
      chk("ld_c3_done", Done, 0);
      chk("ld_c3_stall", Stall, 0);

      // store, ack after 3 wait cycles
      MemWrite = 1; XOut = 16'h0020; WriteData = 16'h1234; #1;
      chk("st_c0_stall", Stall, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         mem.mem_ack = (i == 3); #1;
         chk("st_req", mem.mem_req, 1);
         chk("st_addr", mem.mem_addr, 16'h0020);
         chk("st_wdata", mem.mem_wdata, 16'h1234);
         chk("st_wr", mem.mem_wr, 1);
         chk("st_stall", Stall, 1);
         chk("st_nodone", Done, 0);
      end
      tick();
      mem.mem_ack = 0; #1;
      chk("st_done", Done, 1);
      chk("st_req_off", mem.mem_req, 0);
      chk("st_out_kept", MemOut, 16'hBEEF);
      chk("st_err", err, 0);
      idle_in();
      tick();
      chk("st_done_once", Done, 0);

      // reset during second BUSY cycle
      MemRead = 1; XOut = 16'h0030;
      tick();
      tick();
      rst = 1; #1;
      chk("rm_busy_req", mem.mem_req, 1);
      tick();
      rst = 0; MemRead = 0; #1;
      chk("rm_req", mem.mem_req, 0);
      chk("rm_stall", Stall, 0);
      chk("rm_done", Done, 0);
      chk("rm_out", MemOut, 0);
      chk("rm_err", err, 0);
      chk("rm_addr", mem.mem_addr, 0);
      chk("rm_wr", mem.mem_wr, 0);
      MemRead = 1; XOut = 16'h0040;
      tick();
      mem.mem_ack = 1; mem.mem_rdata = 16'h5A5A;
      tick();
      idle_in(); #1;
      chk("rm_next_done", Done, 1);
      chk("rm_next_out", MemOut, 16'h5A5A);
      chk("rm_next_err", err, 0);
      tick();

      // timeout: 15 BUSY cycles, Done 16 cycles after IDLE
      MemRead = 1; XOut = 16'h0050; #1;
      chk("to_c0_stall", Stall, 1);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk("to_req", mem.mem_req, 1);
         chk("to_nodone", Done, 0);
      end
      tick();
      chk("to_done", Done, 1);
      chk("to_req_off", mem.mem_req, 0);
      chk("to_err", err, 1);
      chk("to_out", MemOut, 0);
      MemRead = 0;
      mem.mem_ack = 1; mem.mem_rdata = 16'hFFFF;
      tick();
      chk("to_late_out", MemOut, 0);
      chk("to_late_done", Done, 0);
      chk("to_late_stall", Stall, 0);
      tick();
      chk("to_late_req", mem.mem_req, 0);
      chk("to_late_out2", MemOut, 0);

      // misaligned load rejected without a request
      do_reset();
      quick_load(16'h0070, 16'h1357, 1'b0);
      chk("ma_pre_out", MemOut, 16'h1357);
      MemRead = 1; XOut = 16'h0011; #1;
      chk("ma_c0_stall", Stall, 1);
      chk("ma_c0_req", mem.mem_req, 0);
      tick();
      chk("ma_c1_done", Done, 1);
      chk("ma_c1_req", mem.mem_req, 0);
      chk("ma_c1_err", err, 1);
      chk("ma_c1_out", MemOut, 0);
      idle_in();
      tick();
      chk("ma_c2_stall", Stall, 0);
      quick_load(16'h0080, 16'h2468, 1'b0);
      chk("ma_sticky_out", MemOut, 16'h2468);
      chk("ma_sticky_err", err, 1);

      // memory fault reported with ack
      do_reset();
      quick_load(16'h0090, 16'hAAAA, 1'b1);
      chk("flt_err", err, 1);
      chk("flt_out", MemOut, 16'hAAAA);

      // read+write conflict: error, write performed
      do_reset();
      MemRead = 1; MemWrite = 1;
      XOut = 16'h0060; WriteData = 16'h7777;
      tick();
      chk("cf_wr", mem.mem_wr, 1);
      chk("cf_err", err, 1);
      chk("cf_wdata", mem.mem_wdata, 16'h7777);
      mem.mem_ack = 1; mem.mem_rdata = 16'h9999;
      tick();
      idle_in(); #1;
      chk("cf_done", Done, 1);
      chk("cf_out", MemOut, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
